// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit                                                          |
// | Iterative 1-bit/cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    // op[0] selects the signed variants; unsigned ops never raise sign flags
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    mag_a = a_neg ? -a : a;
    mag_b = b_neg ? -b : b;

    // Multiply: upper half accumulates, lower half holds the shifting multiplier
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half dividend/quotient
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, opnd_q});
    rem_diff  = rem_shift - {1'b0, opnd_q};
    div_step  = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], rem_ge};

    prod_fix = neg_q     ? -acc_q                    : acc_q;
    quo_fix  = neg_q     ? -acc_q[WIDTH-1:0]         : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]   : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    araw_d    = araw_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hilo_we) begin
          if (hilo_sel) hi_d = hilo_wd;
          else          lo_d = hilo_wd;
        end
        if (start && !flush) begin
          is_div_d  = op[1];
          opnd_d    = op[1] ? mag_b : mag_a;
          araw_d    = a;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
          count_d   = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = is_div_q ? div_step : mul_step;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (opnd_q == '0) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      opnd_q    <= '0;
      araw_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      opnd_q    <= opnd_d;
      araw_q    <= araw_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit                                                       |
// | Directed-vector bench for muldiv_unit at WIDTH = 32.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             flush = 1'b0;
  logic             hilo_we = 1'b0;
  logic             hilo_sel = 1'b0;
  logic [WIDTH-1:0] hilo_wd = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .hilo_wd  (hilo_wd),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one op, then count busy cycles and find the done pulse (bounded).
  task automatic op_check(input string tag, input logic [1:0] o,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                          input bit check_busy);
    int busy_cycles;
    int done_at;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    done_at = -1;
    for (int k = 0; k <= 45; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(done_at), 64'(WIDTH + 1));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    if (check_busy) begin
      check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(WIDTH + 1));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    end
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin
    int done_cnt;
    int done_at;

    // Asynchronous reset, sampled away from any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    op_check("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    op_check("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    op_check("mult_nn",   2'b01, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0);
    op_check("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    op_check("div_negb",  2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    op_check("divu",      2'b10, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0);
    op_check("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    op_check("divu_z",    2'b10, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b0);
    op_check("div_z",     2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

    // Handshake: preload, ignored start and hilo_we while busy, single done
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wd = 32'h1234;
    @(negedge clk);
    hilo_sel = 1'b0; hilo_wd = 32'h5678;
    @(negedge clk);
    hilo_we = 1'b0;
    check("pre_hi", 64'(hi), 64'h1234);
    check("pre_lo", 64'(lo), 64'h5678);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    done_at = -1;
    for (int k = 0; k <= 45; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (k == 8) begin
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wd = 32'hDEAD;
      end else begin
        hilo_we = 1'b0;
      end
      if (k == 12) begin
        check("hs_mid_hi", 64'(hi), 64'h1234);
        check("hs_mid_lo", 64'(lo), 64'h5678);
        check("hs_mid_busy", 64'(busy), 64'd1);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      @(negedge clk);
    end
    check("hs_done_at", 64'(done_at), 64'(WIDTH + 1));
    check("hs_done_cnt", 64'(done_cnt), 64'd1);
    check("hs_hi", 64'(hi), 64'd0);
    check("hs_lo", 64'(lo), 64'd12);

    // Flush at cycle 10 of a DIVU
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_hi", 64'(hi), 64'd0);
    check("fl_lo", 64'(lo), 64'd12);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("fl_no_done", 64'(done_cnt), 64'd0);

    // flush together with start in IDLE cancels the start
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("fl_idle_busy", 64'(busy), 64'd0);

    // hilo_we and start in the same IDLE cycle: write lands, result later wins
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wd = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    check("same_hi_wr", 64'(hi), 64'hABCD);
    repeat (WIDTH + 1) @(negedge clk);
    check("same_done", 64'(done), 64'd1);
    check("same_hi", 64'(hi), 64'd0);
    check("same_lo", 64'(lo), 64'd6);

    // Reset mid-MULT clears everything immediately
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFD; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_hi", 64'(hi), 64'd0);
    check("mrst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    op_check("post_rst", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
